matmul_sequencer: RTL and testbench

//   Control block for the combinational MatrixMultiplier datapath. Holds operand matrices A and B,

---
 rtl/matmul_pkg.sv | 24 ++
 rtl/matmul_result_buf.sv | 41 ++++
 rtl/matmul_sequencer.sv | 125 ++++++++++++
 tb/tb_matmul_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix-multiply sequencer and its result buffer.
// No logic of its own.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  // Settle delay is 0..15, so a 4-bit counter always suffices.
  localparam int SETTLE_CNT_W = 4;

  localparam int MM_DIMS  = 3;

  function automatic int elem_count(input int dims);
    return dims * dims;
  endfunction

  localparam int MM_ELEMS = elem_count(MM_DIMS);

endpackage

// File: rtl/matmul_result_buf.sv
// Result store: DEPTH x WIDTH registers, one write port, one registered read port.
// Read data 1 cycle after rd_addr; out-of-range reads return 0; no backpressure.
module matmul_result_buf #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 9,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_V);
  assign rd_ok = {1'b0, rd_addr} < DEPTH_V;

  // A read of the word being written this cycle returns the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data <= rd_ok ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for a combinational N x N matrix multiplier: holds A/B, walks mm_index, captures C.
// done at N*N*(2+SETTLE)+1 cycles after start; start/loads while busy are ignored/flagged.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MATRIX_DIMS = MM_DIMS,
  parameter int SETTLE      = 0,
  parameter int IDX_W       = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic                                      ld_en,
  input  logic                                      ld_sel,
  input  logic [IDX_W-1:0]                          ld_addr,
  input  logic [WIDTH-1:0]                          ld_data,
  output logic                                      ld_err,
  output logic [MATRIX_DIMS*MATRIX_DIMS*WIDTH-1:0]  mm_a,
  output logic [MATRIX_DIMS*MATRIX_DIMS*WIDTH-1:0]  mm_b,
  output logic [IDX_W-1:0]                          mm_index,
  input  logic [WIDTH-1:0]                          mm_c,
  input  logic [IDX_W-1:0]                          res_addr,
  output logic [WIDTH-1:0]                          res_data,
  output logic                                      busy,
  output logic                                      done
);

  localparam int                      ELEMS       = elem_count(MATRIX_DIMS);
  localparam logic [IDX_W:0]          ELEMS_V     = (IDX_W+1)'(ELEMS);
  localparam logic [IDX_W-1:0]        LAST_IDX    = IDX_W'(ELEMS - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  state_t                  state_q;
  state_t                  state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [SETTLE_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]        a_q [ELEMS];
  logic [WIDTH-1:0]        b_q [ELEMS];
  logic                    ld_err_q;
  logic                    addr_ok;
  logic                    ld_ok;
  logic                    cap_en;

  assign addr_ok = {1'b0, ld_addr} < ELEMS_V;
  // Loads are sampled on state_q, so a load coinciding with start lands before the first ISSUE.
  assign ld_ok   = ld_en && (state_q == IDLE) && addr_ok;
  assign cap_en  = (state_q == CAPTURE);

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign mm_index = idx_q;
  assign ld_err   = ld_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   state_d = (SETTLE > 0) ? WAIT : CAPTURE;
      WAIT:    if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
      CAPTURE: state_d = (idx_q == LAST_IDX) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // idx_q doubles as mm_index: it only moves at start and after a capture,
  // so the datapath sees a stable index for the whole ISSUE/WAIT/CAPTURE span.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (start) idx_q <= '0;
        ISSUE:   cnt_q <= '0;
        WAIT:    cnt_q <= cnt_q + 1'b1;
        CAPTURE: if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ELEMS; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      ld_err_q <= 1'b0;
    end else begin
      if (ld_ok && !ld_sel) a_q[ld_addr] <= ld_data;
      if (ld_ok &&  ld_sel) b_q[ld_addr] <= ld_data;
      ld_err_q <= ld_en && !ld_ok;
    end
  end

  for (genvar g = 0; g < ELEMS; g++) begin : g_operands
    assign mm_a[g*WIDTH +: WIDTH] = a_q[g];
    assign mm_b[g*WIDTH +: WIDTH] = b_q[g];
  end

  matmul_result_buf #(
    .WIDTH  (WIDTH),
    .DEPTH  (ELEMS),
    .ADDR_W (IDX_W)
  ) u_res_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cap_en),
    .wr_addr (idx_q),
    .wr_data (mm_c),
    .rd_addr (res_addr),
    .rd_data (res_data)
  );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench: two sequencers (SETTLE=0 and SETTLE=3) each driving a behavioural 3x3 multiplier.
module tb_matmul_sequencer;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int E  = N * N;
  localparam int IW = 4;
  localparam int FW = E * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start0, start3;
  logic          ld_en, ld_sel;
  logic [IW-1:0] ld_addr, res_addr;
  logic [W-1:0]  ld_data;

  logic          ld_err0, busy0, done0, ld_err3, busy3, done3;
  logic [FW-1:0] mm_a0, mm_b0, mm_a3, mm_b3;
  logic [IW-1:0] mm_index0, mm_index3;
  logic [W-1:0]  mm_c0, mm_c3, res_data0, res_data3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dp(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                      input logic [IW-1:0] idx);
    logic [W-1:0] acc;
    int r, c;
    acc = '0;
    r = int'(idx) / N;
    c = int'(idx) % N;
    if (int'(idx) < E) begin
      for (int k = 0; k < N; k++) begin
        acc = acc + a[(r*N+k)*W +: W] * b[(k*N+c)*W +: W];
      end
    end
    return acc;
  endfunction

  assign mm_c0 = dp(mm_a0, mm_b0, mm_index0);
  assign mm_c3 = dp(mm_a3, mm_b3, mm_index3);

  matmul_sequencer #(.WIDTH(W), .MATRIX_DIMS(N), .SETTLE(0), .IDX_W(IW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err0), .mm_a(mm_a0), .mm_b(mm_b0),
    .mm_index(mm_index0), .mm_c(mm_c0), .res_addr(res_addr), .res_data(res_data0),
    .busy(busy0), .done(done0)
  );

  matmul_sequencer #(.WIDTH(W), .MATRIX_DIMS(N), .SETTLE(3), .IDX_W(IW)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err3), .mm_a(mm_a3), .mm_b(mm_b3),
    .mm_index(mm_index3), .mm_c(mm_c3), .res_addr(res_addr), .res_data(res_data3),
    .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int addr, input logic [W-1:0] data);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = IW'(addr);
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the edge that sampled start.
  task automatic wait_done(input bit which, output int lat, output int busy_low,
                           output int first_idx1);
    lat = -1;
    busy_low = 0;
    first_idx1 = -1;
    for (int c = 1; c <= 200; c++) begin
      if (!(which ? busy3 : busy0)) busy_low++;
      if (first_idx1 < 0 && (which ? mm_index3 : mm_index0) == IW'(1)) first_idx1 = c;
      if (which ? done3 : done0) begin
        lat = c;
        break;
      end
      tick();
    end
  endtask

  task automatic run(input bit which, output int lat, output int busy_low, output int first_idx1);
    if (which) start3 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start3 = 1'b0;
    wait_done(which, lat, busy_low, first_idx1);
  endtask

  task automatic rd(input bit which, input int addr, output logic [W-1:0] data);
    res_addr = IW'(addr);
    tick();
    data = which ? res_data3 : res_data0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_low, fi1, dones;
    logic [W-1:0] d;
    logic [W-1:0] e6 [6];
    e6 = '{32'd5, 32'd10, 32'd15, 32'd4, 32'd5, 32'd6};

    rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; res_addr = '0;
    #12;
    check("rst_busy", W'(busy0), 32'd0);
    check("rst_done", W'(done0), 32'd0);
    check("rst_ld_err", W'(ld_err0), 32'd0);
    check("rst_mm_index", W'(mm_index0), 32'd0);
    check("rst_res_data", res_data0, 32'd0);
    check("rst_mm_a0", mm_a0[W-1:0], 32'd0);
    rst_n = 1'b1;
    tick();

    // A = identity, B = 1..9 -> C = B
    load(1'b0, 0, 32'd1); load(1'b0, 4, 32'd1); load(1'b0, 8, 32'd1);
    for (int i = 0; i < E; i++) load(1'b1, i, W'(i + 1));
    run(1'b0, lat, busy_low, fi1);
    check("t1_latency", W'(lat), 32'd19);
    check("t1_busy_gap", W'(busy_low), 32'd0);
    check("t1_idx_step", W'(fi1), 32'd3);
    tick();
    check("t1_busy_after", W'(busy0), 32'd0);
    check("t1_done_after", W'(done0), 32'd0);
    for (int i = 0; i < E; i++) begin
      rd(1'b0, i, d);
      check($sformatf("t1_res%0d", i), d, W'(i + 1));
    end

    // A = B = all 2 with SETTLE=3 -> every entry 12, index held 5 cycles
    for (int i = 0; i < E; i++) begin
      load(1'b0, i, 32'd2);
      load(1'b1, i, 32'd2);
    end
    run(1'b1, lat, busy_low, fi1);
    check("t2_latency", W'(lat), 32'd46);
    check("t2_busy_gap", W'(busy_low), 32'd0);
    check("t2_idx_hold", W'(fi1), 32'd6);
    tick();
    for (int i = 0; i < E; i++) begin
      rd(1'b1, i, d);
      check($sformatf("t2_res%0d", i), d, 32'd12);
    end

    // A all ones, B = identity -> all ones, no saturation
    for (int i = 0; i < E; i++) begin
      load(1'b0, i, 32'hFFFF_FFFF);
      load(1'b1, i, (i % 4 == 0) ? 32'd1 : 32'd0);
    end
    run(1'b0, lat, busy_low, fi1);
    check("t3_latency", W'(lat), 32'd19);
    tick();
    for (int i = 0; i < E; i++) begin
      rd(1'b0, i, d);
      check($sformatf("t3_res%0d", i), d, 32'hFFFF_FFFF);
    end
    rd(1'b0, 9, d);
    check("t3_res_oor9", d, 32'd0);
    rd(1'b0, 15, d);
    check("t3_res_oor15", d, 32'd0);

    // Out-of-range load in IDLE
    load(1'b0, 9, 32'h1234);
    check("t4_err_addr", W'(ld_err0), 32'd1);
    tick();
    check("t4_err_pulse", W'(ld_err0), 32'd0);
    check("t4_a8_kept", mm_a0[8*W +: W], 32'hFFFF_FFFF);

    // Load while busy, plus a second start mid-run
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    load(1'b0, 0, 32'd7);
    check("t4_err_busy", W'(ld_err0), 32'd1);
    check("t4_a0_kept", mm_a0[W-1:0], 32'hFFFF_FFFF);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    dones = 0;
    for (int c = 0; c < 80; c++) begin
      if (done0) dones++;
      tick();
    end
    check("t5_done_once", W'(dones), 32'd1);
    rd(1'b0, 0, d);
    check("t4_res0_kept", d, 32'hFFFF_FFFF);

    // Reset while processing element 4
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    fi1 = 0;
    for (int c = 0; c < 100; c++) begin
      if (mm_index0 == IW'(4)) begin
        fi1 = 1;
        break;
      end
      tick();
    end
    check("t5_reach_idx4", W'(fi1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", W'(busy0), 32'd0);
    check("t5_rst_done", W'(done0), 32'd0);
    check("t5_rst_index", W'(mm_index0), 32'd0);
    check("t5_rst_res", res_data0, 32'd0);
    check("t5_rst_a0", mm_a0[W-1:0], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t5_idle_after", W'(busy0), 32'd0);

    // Load coinciding with start is used by that run
    load(1'b0, 4, 32'd1); load(1'b0, 8, 32'd1);
    for (int i = 0; i < E; i++) load(1'b1, i, W'(i + 1));
    start0  = 1'b1;
    ld_en   = 1'b1;
    ld_sel  = 1'b0;
    ld_addr = '0;
    ld_data = 32'd5;
    tick();
    start0 = 1'b0;
    ld_en  = 1'b0;
    check("t6_no_err", W'(ld_err0), 32'd0);
    wait_done(1'b0, lat, busy_low, fi1);
    check("t6_latency", W'(lat), 32'd19);
    tick();
    for (int i = 0; i < 6; i++) begin
      rd(1'b0, i, d);
      check($sformatf("t6_res%0d", i), d, e6[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
